serial_subtractor: RTL and testbench

- Bit-serial WIDTH-bit subtractor: Diff = Aop - Bop, processed LSB-first, one bit per clock.
- Single borrow flip-flop and full-subtractor bit logic; this is the inverse-operation counterpart of the team's adder cells.
- Sits beside the FourBitAdder datapath as a low-area subtract unit.
- Start/Busy/Done handshake; result and final borrow held until the next accepted operation.

---
 rtl/serial_subtractor.sv | 124 ++++++++++++
 tb/tb_serial_subtractor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Diff = Aop - Bop, one bit per clock, LSB first.
// A single borrow flip-flop feeds a full-subtractor cell; operands are
// captured into shift registers when Start is accepted.
//
// Handshake: Start is sampled only while idle. When accepted, the operands
// are captured and Busy rises for exactly WIDTH cycles. Start is ignored
// while busy or done, and requests are not queued. Done is then high for one
// cycle. Diff and BorrowOut change only on the edge that raises Done, and
// they hold until the next accepted operation completes.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Aop,
  input  logic [WIDTH-1:0] Bop,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             BorrowOut,
  output logic [1:0]       o_dbg_state
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_borrow_out;
  logic [CNT_W-1:0] r_count;

  logic             w_a_bit;
  logic             w_b_bit;
  logic             w_d;
  logic             w_borrow_next;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  // Full-subtractor cell on the current LSBs plus the stored borrow.
  assign w_a_bit       = r_a[0];
  assign w_b_bit       = r_b[0];
  assign w_d           = w_a_bit ^ w_b_bit ^ r_borrow;
  assign w_borrow_next = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_borrow);
  assign w_last        = (r_count == LAST_CNT);
  assign w_res_next    = {w_d, r_res[WIDTH-1:1]};

  assign Busy        = (r_state == S_RUN);
  assign Done        = (r_state == S_DONE);
  assign Diff        = r_diff;
  assign BorrowOut   = r_borrow_out;
  assign o_dbg_state = r_state;

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: IDLE -> RUN on Start, RUN -> DONE after WIDTH bits, DONE -> IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (Start) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: capture operands on acceptance, shift one bit per RUN cycle, publish on the last bit.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_a          <= '0;
      r_b          <= '0;
      r_res        <= '0;
      r_diff       <= '0;
      r_borrow     <= 1'b0;
      r_borrow_out <= 1'b0;
      r_count      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_a      <= Aop;
            r_b      <= Bop;
            r_borrow <= 1'b0;
            r_count  <= '0;
          end
        end
        S_RUN: begin
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_res    <= w_res_next;
          r_borrow <= w_borrow_next;
          if (w_last) begin
            // Counter returns to zero so it never exceeds WIDTH-1.
            r_count      <= '0;
            r_diff       <= w_res_next;
            r_borrow_out <= w_borrow_next;
          end else begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: one 4-bit and one 16-bit instance, directed
// and random operations checked against an arithmetic reference model.
module tb_serial_subtractor;

  logic        clk;
  logic        rst;

  logic        start4;
  logic [3:0]  a4, b4;
  logic        busy4, done4;
  logic [3:0]  diff4;
  logic        bo4;
  logic [1:0]  st4;

  logic        start16;
  logic [15:0] a16, b16;
  logic        busy16, done16;
  logic [15:0] diff16;
  logic        bo16;
  logic [1:0]  st16;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // Scoreboard: {borrow, diff} expected for each accepted operation.
  logic [16:0] exp_q[$];

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .Clk(clk), .Reset(rst), .Start(start4), .Aop(a4), .Bop(b4),
    .Busy(busy4), .Done(done4), .Diff(diff4), .BorrowOut(bo4),
    .o_dbg_state(st4)
  );

  serial_subtractor #(.WIDTH(16)) u_dut16 (
    .Clk(clk), .Reset(rst), .Start(start16), .Aop(a16), .Bop(b16),
    .Busy(busy16), .Done(done16), .Diff(diff16), .BorrowOut(bo16),
    .o_dbg_state(st16)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain unsigned subtraction modulo 2^w, borrow when a < b.
  function automatic logic [16:0] model(input int w, input int a, input int b);
    int m;
    m = (1 << w) - 1;
    return {(a < b) ? 1'b1 : 1'b0, 16'((a - b) & m)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit wide, input logic s, input logic [15:0] a, input logic [15:0] b);
    if (wide) begin
      start16 = s; a16 = a; b16 = b;
    end else begin
      start4 = s; a4 = a[3:0]; b4 = b[3:0];
    end
  endtask

  // One operation; call with the DUT idle. With disturb set, Start is pulsed
  // with fresh operands throughout RUN.
  task automatic do_op(input bit wide, input int a_in, input int b_in, input bit disturb);
    int          w;
    int          a, b;
    int          busy_n;
    bit          got;
    logic [16:0] exp;
    logic        o_busy, o_done, o_bo;
    logic [15:0] o_diff;
    w      = wide ? 16 : 4;
    a      = a_in & ((1 << w) - 1);
    b      = b_in & ((1 << w) - 1);
    busy_n = 0;
    got    = 1'b0;
    exp_q.push_back(model(w, a, b));
    set_in(wide, 1'b1, 16'(a), 16'(b));
    @(posedge clk);
    #1;
    set_in(wide, 1'b0, 16'($urandom), 16'($urandom));
    for (int c = 1; c <= w + 4 && !got; c++) begin
      @(negedge clk);
      o_busy = wide ? busy16 : busy4;
      o_done = wide ? done16 : done4;
      o_diff = wide ? diff16 : {12'd0, diff4};
      o_bo   = wide ? bo16 : bo4;
      if (o_busy) busy_n++;
      if (o_done) begin
        got = 1'b1;
        exp = exp_q.pop_front();
        chk("diff", 32'(o_diff), 32'(exp[15:0]));
        chk("borrow", 32'(o_bo), 32'(exp[16]));
        chk("done_latency", 32'(c), 32'(w + 1));
      end
      if (disturb) set_in(wide, (c <= w) ? 1'b1 : 1'b0, 16'($urandom), 16'($urandom));
    end
    chk("done_seen", 32'(got), 32'd1);
    if (!got && exp_q.size() > 0) void'(exp_q.pop_front());
    chk("busy_width", 32'(busy_n), 32'(w));
    @(negedge clk);
    chk("done_one_cycle", 32'(wide ? done16 : done4), 32'd0);
    chk("idle_after_done", 32'(wide ? busy16 : busy4), 32'd0);
  endtask

  initial begin
    logic [16:0] exp;
    int          pa[3];
    int          pb[3];
    int          nd, acc, last_c, extra_done;
    bit          prev_busy, hold_checked;

    rst = 1'b1;
    set_in(1'b0, 1'b0, 16'd0, 16'd0);
    set_in(1'b1, 1'b0, 16'd0, 16'd0);
    #12;
    // Reset state
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_done4", 32'(done4), 32'd0);
    chk("rst_diff4", 32'(diff4), 32'd0);
    chk("rst_bo4", 32'(bo4), 32'd0);
    chk("rst_state4", 32'(st4), 32'd0);
    chk("rst_busy16", 32'(busy16), 32'd0);
    chk("rst_diff16", 32'(diff16), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    do_op(1'b0, 9, 5, 1'b0);
    do_op(1'b0, 3, 7, 1'b0);
    do_op(1'b0, 15, 15, 1'b0);
    do_op(1'b0, 0, 1, 1'b0);
    // Start pulsed and operands changed during RUN: result stays 9-5
    do_op(1'b0, 9, 5, 1'b1);
    extra_done = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done4 || busy4) extra_done++;
    end
    chk("no_extra_op", 32'(extra_done), 32'd0);
    do_op(1'b0, 0, 1, 1'b0);

    // Asynchronous reset at bit 2 of 12-2
    set_in(1'b0, 1'b1, 16'd12, 16'd2);
    @(posedge clk);
    #1 set_in(1'b0, 1'b0, 16'd12, 16'd2);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("diff_hold_in_run", 32'(diff4), 32'hF);
    chk("bo_hold_in_run", 32'(bo4), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy4), 32'd0);
    chk("abort_done", 32'(done4), 32'd0);
    chk("abort_diff", 32'(diff4), 32'd0);
    chk("abort_bo", 32'(bo4), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    extra_done = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done4) extra_done++;
    end
    chk("no_done_after_abort", 32'(extra_done), 32'd0);
    do_op(1'b0, 12, 2, 1'b0);

    // Start held high with alternating operands
    pa = '{6, 2, 6};
    pb = '{2, 6, 2};
    nd = 0; acc = 1; last_c = 0;
    prev_busy = 1'b0; hold_checked = 1'b0;
    set_in(1'b0, 1'b1, 16'(pa[0]), 16'(pb[0]));
    for (int c = 1; c <= 40 && nd < 3; c++) begin
      @(negedge clk);
      if (done4) begin
        exp = model(4, pa[nd], pb[nd]);
        chk("held_diff", 32'(diff4), 32'(exp[15:0]));
        chk("held_borrow", 32'(bo4), 32'(exp[16]));
        if (nd > 0) chk("held_period", 32'(c - last_c), 32'd6);
        last_c = c;
        nd++;
        if (nd == 3) start4 = 1'b0;
      end
      if (busy4 && nd == 1 && !hold_checked) begin
        chk("held_diff_hold", 32'(diff4), 32'd4);
        hold_checked = 1'b1;
      end
      if (busy4 && !prev_busy && acc < 3) begin
        a4 = 4'(pa[acc]);
        b4 = 4'(pb[acc]);
        acc++;
      end
      prev_busy = busy4;
    end
    chk("held_done_count", 32'(nd), 32'd3);
    start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Exhaustive WIDTH=4
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        do_op(1'b0, i, j, 1'b0);

    // WIDTH=16 boundaries and random pairs
    do_op(1'b1, 0, 1, 1'b0);
    do_op(1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
    do_op(1'b1, 16'hFFFF, 0, 1'b0);
    for (int k = 0; k < 1000; k++)
      do_op(1'b1, int'($urandom_range(65535, 0)), int'($urandom_range(65535, 0)), 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
